// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding word reads, small instruction FIFO, redirect/flush.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}},
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] inst_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushed
`endif
);

    localparam int                PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic              req_r, req_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r;
    logic [31:0]       inst_mem_r [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem_r   [FIFO_DEPTH];
    logic              push_s;
    logic              pop_s;
    logic              inst_valid_s;
    logic [ADDR_W-1:0] redirect_pc_s;
    logic              unused_low_bits_s;

    // Redirect targets are word aligned; the low address bits carry no information.
    assign redirect_pc_s     = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_low_bits_s = ^redirect_pc[1:0];

    assign inst_valid_s = (count_r != {CNT_W{1'b0}});
    assign pop_s        = inst_valid_s && inst_ready;

    // Fetch FSM next state: request issue, ack handling and redirect priority.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        req_s   = req_r;
        addr_s  = addr_r;
        push_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // The FIFO never holds a word without a reserved slot, so count alone gates issue.
                if (redirect) begin
                    pc_s = redirect_pc_s;
                end else if (count_r < DEPTH_C) begin
                    req_s   = 1'b1;
                    addr_s  = pc_r;
                    state_s = ST_REQ;
                end else begin
                    req_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    pc_s = redirect_pc_s;
                    if (imem_ack) begin
                        req_s   = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                end else if (imem_ack) begin
                    push_s  = 1'b1;
                    pc_s    = pc_r + PC_STEP;
                    req_s   = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DISCARD: begin
                // The stale request stays on the bus untouched until memory answers it.
                if (redirect) begin
                    pc_s = redirect_pc_s;
                end else begin
                    pc_s = pc_r;
                end
                if (imem_ack) begin
                    req_s   = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DISCARD;
                end
            end
            default: begin
                req_s   = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FIFO occupancy: flush wins over push and pop.
    always_comb begin
        count_s = count_r;
        if (redirect) begin
            count_s = {CNT_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + CNT_ONE;
                2'b01:   count_s = count_r - CNT_ONE;
                default: count_s = count_r;
            endcase
        end
    end

    // Fetch state, PC and memory request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            req_r   <= 1'b0;
            addr_r  <= RESET_PC;
            count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            req_r   <= req_s;
            addr_r  <= addr_s;
            count_r <= count_s;
        end
    end

    // Instruction buffer storage and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                inst_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]   <= {ADDR_W{1'b0}};
            end
        end else if (redirect) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                inst_mem_r[wr_ptr_r] <= imem_rdata;
                pc_mem_r[wr_ptr_r]   <= pc_r;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign inst_valid  = inst_valid_s;
    assign instruction = inst_mem_r[rd_ptr_r];
    assign inst_pc     = pc_mem_r[rd_ptr_r];

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_flushed_r;

    // Saturating counters of words accepted into the FIFO and of redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_r <= 32'h0000_0000;
            perf_flushed_r <= 32'h0000_0000;
        end else begin
            if (push_s && (perf_fetched_r != 32'hFFFF_FFFF)) begin
                perf_fetched_r <= perf_fetched_r + 32'h0000_0001;
            end else begin
                perf_fetched_r <= perf_fetched_r;
            end
            if (redirect && (perf_flushed_r != 32'hFFFF_FFFF)) begin
                perf_flushed_r <= perf_flushed_r + 32'h0000_0001;
            end else begin
                perf_flushed_r <= perf_flushed_r;
            end
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_flushed = perf_flushed_r;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory responder pushes expected words, the decoder side pops and compares.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    // stimulus knobs
    logic        ready = 1'b0;
    logic        hold = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = 32'h0;

    // reference model state
    exp_t        exp_q[$];
    logic [31:0] exp_pc = 32'h0;
    logic        disc = 1'b0;
    logic        req_seen = 1'b0;
    int          n_acks = 0;
    int          n_pushed = 0;
    int          n_redir = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .instruction (instruction),
        .inst_pc     (inst_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: drive inputs for the next rising edge, update model, wait one cycle.
    task automatic cycle();
        logic ack_now;
        exp_t e;
        ack_now     = !rst && imem_req && !hold;
        imem_ack    = ack_now;
        imem_rdata  = ack_now ? word_of(imem_addr) : 32'h0;
        redirect    = redir;
        redirect_pc = redir_pc;
        inst_ready  = ready;
        if (!rst) begin
            if (imem_req && !req_seen) begin
                check_val("req_addr", imem_addr, exp_pc);
                req_seen = 1'b1;
            end
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("inst_pc", inst_pc, e.pc);
                    check_val("instruction", instruction, e.word);
                end
            end
            if (ack_now) n_acks++;
            if (redir) begin
                n_redir++;
                exp_q.delete();
                exp_pc = redir_pc & 32'hFFFF_FFFC;
                disc = imem_req && !ack_now;
                if (ack_now) req_seen = 1'b0;
            end else if (ack_now) begin
                if (!disc) begin
                    exp_q.push_back('{pc: imem_addr, word: word_of(imem_addr)});
                    exp_pc = exp_pc + 32'd4;
                    n_pushed++;
                end
                disc = 1'b0;
                req_seen = 1'b0;
            end
        end
        redir = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        check_val("rst_req", {31'd0, imem_req}, 32'd0);
        check_val("rst_addr", imem_addr, 32'h0);
        check_val("rst_valid", {31'd0, inst_valid}, 32'd0);
        check_val("rst_instr", instruction, 32'h0);
        check_val("rst_pc", inst_pc, 32'h0);
        rst = 1'b0;
        exp_q.delete();
        exp_pc = 32'h0;
        disc = 1'b0;
        req_seen = 1'b0;
        n_acks = 0;
        n_pushed = 0;
        n_redir = 0;
    endtask

    task automatic drain();
        hold  = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        check_val("drain_left", exp_q.size(), 32'd0);
        check_val("drain_valid", {31'd0, inst_valid}, 32'd0);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !imem_req; i++) cycle();
        check_val(tag, {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);

        // Streaming with immediate acks and a ready decoder.
        ready = 1'b1;
        do_reset();
        cycle();
        check_val("first_req", {31'd0, imem_req}, 32'd1);
        cycle();
        check_val("ack_latency", {31'd0, inst_valid}, 32'd1);
        for (int i = 0; i < 16; i++) cycle();
        drain();

        // Backpressure: decoder stalled 10 cycles fills the 2-entry buffer.
        hold  = 1'b0;
        ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) cycle();
        check_val("bp_acks", n_acks, 32'd2);
        check_val("bp_req_low", {31'd0, imem_req}, 32'd0);
        check_val("bp_valid", {31'd0, inst_valid}, 32'd1);
        drain();

        // Redirect to 0x103 while the request for 0x8 is outstanding.
        hold  = 1'b0;
        ready = 1'b1;
        do_reset();
        for (int i = 0; i < 30 && !(imem_req && imem_addr == 32'h8); i++) cycle();
        check_val("req8_seen", imem_addr, 32'h8);
        hold = 1'b1;
        redir = 1'b1;
        redir_pc = 32'h103;
        cycle();
        check_val("disc_req_held", {31'd0, imem_req}, 32'd1);
        check_val("disc_addr_held", imem_addr, 32'h8);
        check_val("disc_flushed", {31'd0, inst_valid}, 32'd0);
        hold = 1'b0;
        cycle();
        wait_req("redir_req");
        check_val("redir_addr", imem_addr, 32'h100);
        for (int i = 0; i < 10 && !inst_valid; i++) cycle();
        check_val("redir_first_pc", inst_pc, 32'h100);
        for (int i = 0; i < 6; i++) cycle();
        drain();

        // Redirect in the same cycle as an ack.
        hold = 1'b0;
        wait_req("pre_ack_req");
        redir = 1'b1;
        redir_pc = 32'h40;
        cycle();
        check_val("ackredir_empty", {31'd0, inst_valid}, 32'd0);
        check_val("ackredir_req", {31'd0, imem_req}, 32'd0);
        wait_req("ackredir_next");
        check_val("ackredir_addr", imem_addr, 32'h40);
        for (int i = 0; i < 6; i++) cycle();
        drain();

        // PC wrap at the top of the address space.
        hold = 1'b0;
        redir = 1'b1;
        redir_pc = 32'hFFFF_FFFC;
        cycle();
        for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'hFFFF_FFFC); i++) cycle();
        check_val("wrap_top", imem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 20 && !(imem_req && imem_addr != 32'hFFFF_FFFC); i++) cycle();
        check_val("wrap_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) cycle();
        drain();

        // Reset asserted while a request is pending.
        hold = 1'b1;
        wait_req("pre_rst_req");
        rst = 1'b1;
        cycle();
        check_val("midrst_req", {31'd0, imem_req}, 32'd0);
        check_val("midrst_valid", {31'd0, inst_valid}, 32'd0);
        hold = 1'b0;
        do_reset();
        cycle();
        check_val("post_rst_req", {31'd0, imem_req}, 32'd1);
        check_val("post_rst_addr", imem_addr, 32'h0);

        // Five fetched words and two redirects.
        for (int i = 0; i < 30 && n_pushed < 3; i++) cycle();
        redir = 1'b1;
        redir_pc = 32'h200;
        cycle();
        for (int i = 0; i < 30 && n_pushed < 5; i++) cycle();
        hold = 1'b1;
        redir = 1'b1;
        redir_pc = 32'h300;
        cycle();
        cycle();
        check_val("perf_model_fetch", n_pushed, 32'd5);
`ifdef IFU_PERF_CNT_EN
        check_val("perf_fetched", perf_fetched, 32'd5);
        check_val("perf_flushed", perf_flushed, 32'd2);
`endif
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
